layer_input_sequencer: RTL and testbench
========================================

LAYER_INPUT_SEQUENCER -- requirements
Module: layer_input_sequencer

Interface
REQ-001 SHALL have parameter NUM_UNKNOWNS, default 2: number of equation unknowns.
REQ-002 SHALL have parameter NUM_NONLIN, default 1: number of nonlinear neurons; N = NUM_UNKNOWNS+NUM_NONLIN is the frame length in cycles.
REQ-003 SHALL have parameter BIT_WIDTH, default 32: float size.
REQ-004 SHALL have parameter EXTRA_BITS, default 2: Flopoco exception bits, legal values 0 or 2; W = BIT_WIDTH+EXTRA_BITS.
REQ-005 SHALL have parameter ONE_VALUE, default {2'b01,32'h3F800000}: W-bit encoding of 1.0, used as the bias slot.
REQ-006 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port IN_VECTOR, input, W*(N-1): operand vector; element k occupies bits [W*(k+1)-1 : W*k].
REQ-009 SHALL have ports IN_VALID (input, 1) and IN_READY (output, 1): vector handshake; transfer occurs when both are high on a clock edge.
REQ-010 SHALL have port FLUSH, input, 1: synchronous abort of the current burst.
REQ-011 SHALL have port INPUT_SCALER, output, W: one float per cycle toward the layer.
REQ-012 SHALL have port SCALER_VALID, output, 1: INPUT_SCALER carries a frame slot.
REQ-013 SHALL have port SLOT, output, clog2(N): index of the current slot.
REQ-014 SHALL have port LAYER_RESET, output, 1: one-cycle accumulator-clear pulse toward the layer.
REQ-015 SHALL have port INITIAL_READ_FLAG, output, 1: high for every slot of the first frame of a burst.

Function
REQ-016 SHALL implement the states IDLE, PRIME and STREAM.
REQ-017 IDLE SHALL drive IN_READY=1; a transfer SHALL capture IN_VECTOR into the hold register and move to PRIME.
REQ-018 PRIME SHALL last exactly one cycle, assert LAYER_RESET and move the hold register into the stream register; the next state SHALL be STREAM with SLOT=0.
REQ-019 STREAM SHALL output, for SLOT s = 0..N-2, INPUT_SCALER = element s and, for SLOT N-1, ONE_VALUE (bias), with SCALER_VALID=1.
REQ-020 Latency SHALL be: transfer at edge t, then LAYER_RESET at cycle t+1, then slot 0 at cycle t+2.
REQ-021 In STREAM, IN_READY SHALL be 1 while the hold register is empty; a vector accepted during a frame SHALL wait in the hold register.
REQ-022 At SLOT N-1 with the hold register full, the next cycle SHALL be slot 0 of the next frame (no gap, no LAYER_RESET), INITIAL_READ_FLAG=0, and the hold register SHALL be transferred to the stream register.
REQ-023 A transfer coinciding with SLOT N-1 while the hold register is empty SHALL be treated as back-to-back, as in REQ-022.
REQ-024 At SLOT N-1 with no pending vector, the next state SHALL be IDLE.
REQ-025 In IDLE and PRIME, INPUT_SCALER SHALL be all zero and SCALER_VALID SHALL be 0.
REQ-026 SLOT SHALL wrap from N-1 to 0 and SHALL hold 0 outside STREAM.
REQ-027 FLUSH SHALL force IDLE on the next edge, empty the hold register, ignore any same-cycle transfer, and deassert all outputs except IN_READY.
REQ-028 INITIAL_READ_FLAG SHALL be 1 from PRIME through the first SLOT N-1 of a burst, and 0 otherwise.
REQ-029 The block SHALL perform no arithmetic; data SHALL pass bit-exact.

Reset
REQ-030 RESET low SHALL asynchronously force IDLE, empty the hold register, and set INPUT_SCALER=0, SCALER_VALID=0, SLOT=0, LAYER_RESET=0, INITIAL_READ_FLAG=0, IN_READY=0.
REQ-031 IN_READY SHALL go to 1 on the first clock edge after RESET deasserts; reset asserted mid-frame SHALL discard the frame without completing it.

Structure
REQ-032 State encodings, the default ONE_VALUE and the W/N width helpers SHALL live in the shared definitions file.
REQ-033 A single sub-module, vector_hold_reg (a one-entry register with full flag), is natural; everything else SHALL be in one module.

Verification
REQ-034 Single vector, N=3, elements {A=0x0_40000000, B=0x1_3F800000}: transfer at edge 0 -> LAYER_RESET at cycle 1; cycles 2,3,4 output A, B, ONE_VALUE with SLOT 0,1,2 and INITIAL_READ_FLAG=1; cycle 5 is IDLE.
REQ-035 Two vectors V1, V2, with V2 offered during V1 slot 1 -> six contiguous valid slots; second frame has INITIAL_READ_FLAG=0; one LAYER_RESET only.
REQ-036 IN_VALID held high for 4 vectors -> IN_READY drops when the hold register is full; no vector lost or duplicated; 12 contiguous slots.
REQ-037 FLUSH at slot 1 with a vector pending -> IDLE next cycle; SCALER_VALID=0; pending vector dropped; a new vector afterwards restarts with PRIME.
REQ-038 RESET pulsed low at slot 1 -> all outputs 0 immediately (no clock edge needed); IN_READY=1 one edge after release.

Source files
------------

// File: rtl/layer_input_sequencer_pkg.sv
// Shared definitions for the layer input sequencer: state encoding, default
// float constants and the word/frame width helpers.
package layer_input_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2
   } seq_state_t;

   localparam int DEFAULT_BIT_WIDTH  = 32;
   localparam int DEFAULT_EXTRA_BITS = 2;

   // Flopoco encoding of 1.0: exception bits 2'b01 (normal) over IEEE single 1.0.
   localparam logic [33:0] DEFAULT_ONE_VALUE = {2'b01, 32'h3F800000};

   function automatic int word_width(input int bit_width, input int extra_bits);
      return bit_width + extra_bits;
   endfunction

   function automatic int frame_len(input int num_unknowns, input int num_nonlin);
      return num_unknowns + num_nonlin;
   endfunction

   function automatic int slot_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_input_sequencer_if.sv
// Vector handshake plus the per-cycle scalar stream toward the layer.
interface layer_input_sequencer_if #(
   parameter int W  = 34,
   parameter int N  = 3,
   parameter int SW = 2
);
   logic [W*(N-1)-1:0] IN_VECTOR;
   logic               IN_VALID;
   logic               IN_READY;
   logic               FLUSH;
   logic [W-1:0]       INPUT_SCALER;
   logic               SCALER_VALID;
   logic [SW-1:0]      SLOT;
   logic               LAYER_RESET;
   logic               INITIAL_READ_FLAG;

   modport master (
      output IN_VECTOR, IN_VALID, FLUSH,
      input  IN_READY, INPUT_SCALER, SCALER_VALID, SLOT, LAYER_RESET, INITIAL_READ_FLAG
   );

   modport slave (
      input  IN_VECTOR, IN_VALID, FLUSH,
      output IN_READY, INPUT_SCALER, SCALER_VALID, SLOT, LAYER_RESET, INITIAL_READ_FLAG
   );
endinterface

// File: rtl/vector_hold_reg.sv
// One-entry holding register with a full flag; load wins over clear.
module vector_hold_reg #(
   parameter int VW = 68
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          load,
   input  logic          clear,
   input  logic [VW-1:0] load_data,
   output logic [VW-1:0] data,
   output logic          full
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

   // NOTE: the data word is qualified by full, so it needs no reset and stays a plain register.
   always_ff @(posedge CLK) begin
      if (load) begin
         data <= load_data;
      end
   end

endmodule

// File: rtl/layer_input_sequencer.sv
// Serialises one operand vector per frame into the layer, appending a 1.0 bias
// slot, with back-to-back frames when a vector is already waiting.
module layer_input_sequencer
   import layer_input_sequencer_pkg::*;
#(
   parameter int NUM_UNKNOWNS = 2,
   parameter int NUM_NONLIN   = 1,
   parameter int BIT_WIDTH    = DEFAULT_BIT_WIDTH,
   parameter int EXTRA_BITS   = DEFAULT_EXTRA_BITS,
   parameter logic [word_width(BIT_WIDTH, EXTRA_BITS)-1:0] ONE_VALUE = DEFAULT_ONE_VALUE
) (
   input logic                    CLK,
   input logic                    RESET,
   layer_input_sequencer_if.slave bus
);

   localparam int W  = word_width(BIT_WIDTH, EXTRA_BITS);
   localparam int N  = frame_len(NUM_UNKNOWNS, NUM_NONLIN);
   localparam int SW = slot_width(N);
   localparam int VW = W * (N - 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

   seq_state_t    state;
   logic [VW-1:0] stream_vec;
   logic [VW-1:0] hold_data;
   logic          hold_full;
   logic          xfer;
   logic          at_last;
   logic          rollover;
   logic          hold_load;
   logic          hold_unload;
   logic [VW-1:0] next_vec;
   logic [SW-1:0] slot_inc;

   function automatic logic [W-1:0] slot_word(input logic [VW-1:0] v, input logic [SW-1:0] s);
      logic [W-1:0] word;
      word = ONE_VALUE;
      for (int k = 0; k < N - 1; k++) begin
         if (int'(s) == k) word = v[k*W +: W];
      end
      return word;
   endfunction

   assign xfer        = bus.IN_VALID & bus.IN_READY & ~bus.FLUSH;
   assign at_last     = (state == ST_STREAM) && (bus.SLOT == LAST_SLOT);
   // A vector arriving on the bias slot bypasses the hold register straight into the next frame.
   assign rollover    = at_last && (hold_full || xfer);
   assign hold_load   = xfer && !at_last;
   assign hold_unload = (state == ST_PRIME) || (at_last && hold_full);
   assign next_vec    = hold_full ? hold_data : bus.IN_VECTOR;
   assign slot_inc    = bus.SLOT + SW'(1);

   vector_hold_reg #(.VW(VW)) u_hold (
      .CLK       (CLK),
      .RESET     (RESET),
      .load      (hold_load),
      .clear     (hold_unload | bus.FLUSH),
      .load_data (bus.IN_VECTOR),
      .data      (hold_data),
      .full      (hold_full)
   );

   always_ff @(posedge CLK) begin
      if (hold_unload || rollover) begin
         stream_vec <= next_vec;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state                 <= ST_IDLE;
         bus.IN_READY          <= 1'b0;
         bus.INPUT_SCALER      <= '0;
         bus.SCALER_VALID      <= 1'b0;
         bus.SLOT              <= '0;
         bus.LAYER_RESET       <= 1'b0;
         bus.INITIAL_READ_FLAG <= 1'b0;
      end else if (bus.FLUSH) begin
         state                 <= ST_IDLE;
         bus.IN_READY          <= 1'b1;
         bus.INPUT_SCALER      <= '0;
         bus.SCALER_VALID      <= 1'b0;
         bus.SLOT              <= '0;
         bus.LAYER_RESET       <= 1'b0;
         bus.INITIAL_READ_FLAG <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.IN_READY <= !xfer;
               if (xfer) begin
                  state                 <= ST_PRIME;
                  bus.LAYER_RESET       <= 1'b1;
                  bus.INITIAL_READ_FLAG <= 1'b1;
               end
            end
            ST_PRIME: begin
               state            <= ST_STREAM;
               bus.IN_READY     <= 1'b1;
               bus.LAYER_RESET  <= 1'b0;
               bus.SLOT         <= '0;
               bus.INPUT_SCALER <= slot_word(hold_data, '0);
               bus.SCALER_VALID <= 1'b1;
            end
            ST_STREAM: begin
               if (!at_last) begin
                  bus.SLOT         <= slot_inc;
                  bus.INPUT_SCALER <= slot_word(stream_vec, slot_inc);
                  bus.IN_READY     <= !(hold_full || xfer);
               end else if (rollover) begin
                  bus.SLOT              <= '0;
                  bus.INPUT_SCALER      <= slot_word(next_vec, '0);
                  bus.INITIAL_READ_FLAG <= 1'b0;
                  bus.IN_READY          <= 1'b1;
               end else begin
                  state                 <= ST_IDLE;
                  bus.SLOT              <= '0;
                  bus.INPUT_SCALER      <= '0;
                  bus.SCALER_VALID      <= 1'b0;
                  bus.INITIAL_READ_FLAG <= 1'b0;
                  bus.IN_READY          <= 1'b1;
               end
            end
            default: begin
               state        <= ST_IDLE;
               bus.IN_READY <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_input_sequencer.sv
// Randomised and directed bench for layer_input_sequencer against a frame
// schedule model: each accepted vector books N output cycles in a timeline.
module tb_layer_input_sequencer;
   import layer_input_sequencer_pkg::*;

   localparam int W    = 34;
   localparam int N    = 3;
   localparam int SW   = 2;
   localparam int VW   = W * (N - 1);
   localparam int MAXC = 2048;
   localparam logic [W-1:0] ONE = DEFAULT_ONE_VALUE;

   logic CLK;
   logic RESET;

   layer_input_sequencer_if #(.W(W), .N(N), .SW(SW)) bus ();

   layer_input_sequencer dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Expected timeline, indexed by the edge after which a cycle is observed.
   bit [W-1:0]  m_word  [MAXC];
   bit [SW-1:0] m_slot  [MAXC];
   bit          m_valid [MAXC];
   bit          m_irf   [MAXC];
   bit          m_lr    [MAXC];
   bit          m_busy  [MAXC];

   int edge_cnt   = 0;
   int last_l     = -100;
   int ready_from = MAXC;
   int n_checks   = 0;
   int n_fail     = 0;
   bit last_xfer  = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
      end
   endtask

   function automatic void wipe(input int from);
      for (int c = from; c < MAXC; c++) begin
         m_word[c] = '0; m_slot[c] = '0; m_valid[c] = 1'b0;
         m_irf[c] = 1'b0; m_lr[c] = 1'b0; m_busy[c] = 1'b0;
      end
   endfunction

   // A vector accepted no later than the edge after the previous bias slot
   // continues the burst; otherwise it opens a new burst with a prime cycle.
   function automatic void schedule(input int e, input bit [VW-1:0] v);
      int  s;
      bit  init;
      if (e <= last_l + 1) begin
         s = last_l + 1;
         init = 1'b0;
      end else begin
         s = e + 1;
         init = 1'b1;
         m_lr[e] = 1'b1;
         m_irf[e] = 1'b1;
      end
      for (int c = e; c < s; c++) m_busy[c] = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (s + k < MAXC) begin
            m_valid[s+k] = 1'b1;
            m_slot[s+k]  = SW'(k);
            m_word[s+k]  = (k < N - 1) ? v[k*W +: W] : ONE;
            m_irf[s+k]   = init;
         end
      end
      last_l = s + N - 1;
   endfunction

   task automatic compare(input int c);
      check("scaler_valid", 64'(bus.SCALER_VALID), 64'(m_valid[c]));
      check("slot", 64'(bus.SLOT), 64'(m_slot[c]));
      check("input_scaler", 64'(bus.INPUT_SCALER), 64'(m_word[c]));
      check("initial_read_flag", 64'(bus.INITIAL_READ_FLAG), 64'(m_irf[c]));
      check("layer_reset", 64'(bus.LAYER_RESET), 64'(m_lr[c]));
      check("in_ready", 64'(bus.IN_READY), 64'((c >= ready_from) && !m_busy[c]));
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      int e;
      bit xfer;
      e = edge_cnt + 1;
      xfer = 1'b0;
      if (!RESET) begin
         wipe(e);
         last_l = -100;
         ready_from = MAXC;
      end else if (bus.FLUSH) begin
         wipe(e);
         last_l = -100;
      end else if (bus.IN_VALID && bus.IN_READY) begin
         xfer = 1'b1;
         schedule(e, bus.IN_VECTOR);
      end
      last_xfer = xfer;
      @(posedge CLK);
      edge_cnt = e;
      @(negedge CLK);
      if (e < MAXC) compare(e);
   endtask

   function automatic logic [W-1:0] rand_word();
      return W'({$urandom(), $urandom()});
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < N - 1; k++) v[k*W +: W] = rand_word();
      return v;
   endfunction

   task automatic idle(input int cycles);
      bus.IN_VALID = 1'b0;
      bus.FLUSH = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic send(input logic [VW-1:0] v);
      bus.IN_VALID = 1'b1;
      bus.IN_VECTOR = v;
      tick();
      bus.IN_VALID = 1'b0;
   endtask

   logic [VW-1:0] vq [4];
   int            idx;

   initial begin
      RESET = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.FLUSH = 1'b0;
      bus.IN_VECTOR = '0;
      wipe(0);

      idle(3);
      RESET = 1'b1;
      ready_from = edge_cnt + 1;
      idle(2);

      // Single vector: A then B then bias.
      send({34'h1_3F800000, 34'h0_40000000});
      idle(5);

      // Second vector offered during slot 1 of the first frame.
      send(rand_vec());
      idle(2);
      send(rand_vec());
      idle(8);

      // Valid held high across four vectors.
      for (int k = 0; k < 4; k++) vq[k] = rand_vec();
      idx = 0;
      for (int t = 0; t < 60 && idx < 4; t++) begin
         bus.IN_VALID = 1'b1;
         bus.IN_VECTOR = vq[idx];
         tick();
         if (last_xfer) idx++;
      end
      bus.IN_VALID = 1'b0;
      check("burst4_accepted", 64'(idx), 64'd4);
      idle(16);

      // Flush at slot 1 with a vector pending, then restart.
      send(rand_vec());
      idle(1);
      send(rand_vec());
      bus.FLUSH = 1'b1;
      tick();
      bus.FLUSH = 1'b0;
      idle(2);
      send(rand_vec());
      idle(6);

      // Asynchronous reset at slot 1.
      send(rand_vec());
      idle(2);
      #1 RESET = 1'b0;
      #1;
      check("rst_scaler_valid", 64'(bus.SCALER_VALID), 64'd0);
      check("rst_input_scaler", 64'(bus.INPUT_SCALER), 64'd0);
      check("rst_slot", 64'(bus.SLOT), 64'd0);
      check("rst_layer_reset", 64'(bus.LAYER_RESET), 64'd0);
      check("rst_initial_read_flag", 64'(bus.INITIAL_READ_FLAG), 64'd0);
      check("rst_in_ready", 64'(bus.IN_READY), 64'd0);
      idle(2);
      RESET = 1'b1;
      ready_from = edge_cnt + 1;
      idle(3);
      send(rand_vec());
      idle(6);

      // Random traffic with occasional flushes.
      for (int t = 0; t < 700; t++) begin
         bus.IN_VALID = ($urandom_range(0, 99) < 55);
         bus.IN_VECTOR = rand_vec();
         bus.FLUSH = ($urandom_range(0, 99) < 3);
         tick();
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
